// File: rtl/rv32i_types_pkg.sv
// rtl/rv32i_types_pkg.sv - shared RV32I pipeline types for the execute stage
// Purpose: opcode/ALU/branch/multiply encodings, the control word and the
//          inter-stage register bundle shared by decode, execute and memory.
// Ports:   none (package).
package rv32i_types;

   typedef enum logic [6:0] {
      OPC_LUI    = 7'b0110111,
      OPC_AUIPC  = 7'b0010111,
      OPC_JAL    = 7'b1101111,
      OPC_JALR   = 7'b1100111,
      OPC_BRANCH = 7'b1100011,
      OPC_LOAD   = 7'b0000011,
      OPC_STORE  = 7'b0100011,
      OPC_OP_IMM = 7'b0010011,
      OPC_OP     = 7'b0110011
   } opcode_t;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
   } alu_ops_t;

   typedef enum logic [2:0] {
      BR_BEQ  = 3'b000,
      BR_BNE  = 3'b001,
      BR_BLT  = 3'b100,
      BR_BGE  = 3'b101,
      BR_BLTU = 3'b110,
      BR_BGEU = 3'b111
   } branch_funct3_t;

   typedef enum logic [2:0] {
      MF_MUL    = 3'b000,
      MF_MULH   = 3'b001,
      MF_MULHSU = 3'b010,
      MF_MULHU  = 3'b011
   } mul_funct3_t;

   // JALR clears bit 0 of the computed target.
   localparam logic [31:0] JALR_LSB_MASK = 32'hFFFF_FFFE;

   typedef struct packed {
      opcode_t     opcode;
      logic [2:0]  funct3;
      alu_ops_t    alu_op;
      logic        use_imm;   // operand_b = imm instead of rs2_v
      logic        is_mul;    // OP opcode with M-extension funct7
   } ctrl_t;

   typedef struct packed {
      logic [31:0] pc;
      ctrl_t       ctrl;
      logic [31:0] rs1_v;
      logic [31:0] rs2_v;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic [31:0] alu;
      logic [31:0] br;
      logic        valid;
   } stage_regs;

endpackage

// File: rtl/ex_stage_mul_iter.sv
// rtl/ex_stage_mul_iter.sv - iterative shift-add multiplier for RV32 MUL/MULH/MULHSU/MULHU
// Purpose: IDLE/BUSY/DONE FSM, one multiplier bit per BUSY cycle, sign fix-up at the end.
//          Optional EX_MUL_EARLY_OUT_EN: leave BUSY once the remaining multiplier bits are zero.
// Ports:   clk, rst (sync, active-high); start (valid mul op present), abort (flush),
//          ack (result consumed, leaves DONE); op (mul funct3), a/b (rs1/rs2);
//          done (result valid), result (32-bit selected half).
module mul_iter
   import rv32i_types::*;
#(
   parameter int MUL_CYCLES = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   input  logic        ack,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        done,
   output logic [31:0] result
);

   localparam int CW = $clog2(MUL_CYCLES) + 1;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [63:0]   acc_q, acc_d;
   logic [63:0]   mcand_q, mcand_d;
   logic [31:0]   mplier_q, mplier_d;
   logic          neg_q, neg_d;
   logic          hi_q, hi_d;

   logic          a_signed, b_signed;
   logic [31:0]   mag_a, mag_b;
   logic          last_iter;
   logic [63:0]   prod;

   // Multiply magnitudes; the sign is restored after accumulation.
   always_comb begin
      a_signed = (op == MF_MULH) || (op == MF_MULHSU);
      b_signed = (op == MF_MULH);
      mag_a    = (a_signed && a[31]) ? (32'd0 - a) : a;
      mag_b    = (b_signed && b[31]) ? (32'd0 - b) : b;
   end

`ifdef EX_MUL_EARLY_OUT_EN
   // Bits above the one consumed this cycle are all zero: nothing left to add.
   assign last_iter = (cnt_q == CW'(MUL_CYCLES - 1)) || (mplier_q[31:1] == 31'd0);
`else
   assign last_iter = (cnt_q == CW'(MUL_CYCLES - 1));
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      neg_d    = neg_q;
      hi_d     = hi_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d  = S_BUSY;
               cnt_d    = '0;
               acc_d    = '0;
               mcand_d  = {32'd0, mag_a};
               mplier_d = mag_b;
               neg_d    = (a_signed && a[31]) ^ (b_signed && b[31]);
               hi_d     = (op != MF_MUL);
            end
         end
         S_BUSY: begin
            if (mplier_q[0]) acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (last_iter) state_d = S_DONE;
         end
         S_DONE: begin
            if (ack) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (abort) state_d = S_IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         neg_q    <= 1'b0;
         hi_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         neg_q    <= neg_d;
         hi_q     <= hi_d;
      end
   end

   assign prod   = neg_q ? (64'd0 - acc_q) : acc_q;
   assign result = hi_q ? prod[63:32] : prod[31:0];
   assign done   = (state_q == S_DONE);

endmodule

// File: rtl/pipe_reg.sv
// rtl/pipe_reg.sv - shared enable-gated pipeline register
// Purpose: holds a WIDTH-bit bundle; loads d when en, clears on rst.
// Ports:   clk, rst (sync, active-high), en (load), d (next value), q (held value).
module pipe_reg #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] data_d;
   logic [WIDTH-1:0] data_q;

   always_comb begin
      data_d = data_q;
      if (en) data_d = d;
   end

   always_ff @(posedge clk) begin
      if (rst) data_q <= '0;
      else     data_q <= data_d;
   end

   assign q = data_q;

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - RV32IM execute stage: ALU, branch resolution, iterative multiplier
// Purpose: computes alu/br for the decode bundle and registers it for the memory stage;
//          MUL* ops run in mul_iter and stall upstream until done.
//          Optional EX_MUL_EARLY_OUT_EN shortens multiplies (see mul_iter).
// Ports:   clk, rst (sync, active-high); regs_in (decode bundle); stall_in (downstream hold);
//          flush (kill EX and multiply); regs_out (registered bundle); stall_out (upstream hold);
//          br_taken / br_target (combinational fetch redirect).
module ex_stage
   import rv32i_types::*;
#(
   parameter int MUL_CYCLES = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  stage_regs   regs_in,
   input  logic        stall_in,
   input  logic        flush,
   output stage_regs   regs_out,
   output logic        stall_out,
   output logic        br_taken,
   output logic [31:0] br_target
);

   logic        advance;
   logic        is_mul_op, is_branch, is_jal, is_jalr;
   logic        mul_done;
   logic [31:0] mul_result;
   logic [31:0] op_b, alu_res, alu;
   logic [4:0]  shamt;
   logic        cmp;
   stage_regs   out_d;

   assign advance   = !stall_in;
   assign is_mul_op = regs_in.valid && (regs_in.ctrl.opcode == OPC_OP) && regs_in.ctrl.is_mul;
   assign is_branch = (regs_in.ctrl.opcode == OPC_BRANCH);
   assign is_jal    = (regs_in.ctrl.opcode == OPC_JAL);
   assign is_jalr   = (regs_in.ctrl.opcode == OPC_JALR);

   mul_iter #(.MUL_CYCLES(MUL_CYCLES)) u_mul (
      .clk    (clk),
      .rst    (rst),
      .start  (is_mul_op && !flush),
      .abort  (flush),
      .ack    (advance),
      .op     (regs_in.ctrl.funct3),
      .a      (regs_in.rs1_v),
      .b      (regs_in.rs2_v),
      .done   (mul_done),
      .result (mul_result)
   );

   always_comb begin
      op_b  = regs_in.ctrl.use_imm ? regs_in.imm : regs_in.rs2_v;
      shamt = op_b[4:0];
      case (regs_in.ctrl.alu_op)
         ALU_ADD:  alu_res = regs_in.rs1_v + op_b;
         ALU_SUB:  alu_res = regs_in.rs1_v - op_b;
         ALU_SLL:  alu_res = regs_in.rs1_v << shamt;
         ALU_SLT:  alu_res = {31'd0, $signed(regs_in.rs1_v) < $signed(op_b)};
         ALU_SLTU: alu_res = {31'd0, regs_in.rs1_v < op_b};
         ALU_XOR:  alu_res = regs_in.rs1_v ^ op_b;
         ALU_SRL:  alu_res = regs_in.rs1_v >> shamt;
         ALU_SRA:  alu_res = $unsigned($signed(regs_in.rs1_v) >>> shamt);
         ALU_OR:   alu_res = regs_in.rs1_v | op_b;
         ALU_AND:  alu_res = regs_in.rs1_v & op_b;
         default:  alu_res = regs_in.rs1_v + op_b;
      endcase
   end

   always_comb begin
      case (regs_in.ctrl.funct3)
         BR_BEQ:  cmp = (regs_in.rs1_v == regs_in.rs2_v);
         BR_BNE:  cmp = (regs_in.rs1_v != regs_in.rs2_v);
         BR_BLT:  cmp = ($signed(regs_in.rs1_v) <  $signed(regs_in.rs2_v));
         BR_BGE:  cmp = ($signed(regs_in.rs1_v) >= $signed(regs_in.rs2_v));
         BR_BLTU: cmp = (regs_in.rs1_v <  regs_in.rs2_v);
         BR_BGEU: cmp = (regs_in.rs1_v >= regs_in.rs2_v);
         default: cmp = 1'b0;
      endcase
   end

   always_comb begin
      case (regs_in.ctrl.opcode)
         OPC_LOAD, OPC_STORE: alu = regs_in.rs1_v + regs_in.imm;
         OPC_LUI:             alu = regs_in.imm;
         OPC_AUIPC:           alu = regs_in.pc + regs_in.imm;
         OPC_JAL, OPC_JALR:   alu = regs_in.pc + 32'd4;
         OPC_OP:              alu = regs_in.ctrl.is_mul ? mul_result : alu_res;
         default:             alu = alu_res;
      endcase

      br_target = is_jalr ? ((regs_in.rs1_v + regs_in.imm) & JALR_LSB_MASK)
                          : (regs_in.pc + regs_in.imm);
      br_taken  = regs_in.valid && !flush && ((is_branch && cmp) || is_jal || is_jalr);

      // A multiply only produces a valid bundle in its DONE cycle; before that, bubbles.
      out_d       = regs_in;
      out_d.alu   = alu;
      out_d.br    = {31'd0, is_branch && cmp};
      out_d.valid = regs_in.valid && !flush && (!is_mul_op || mul_done);
   end

   assign stall_out = stall_in || (is_mul_op && !mul_done);

   pipe_reg #(.WIDTH($bits(stage_regs))) u_out_reg (
      .clk (clk),
      .rst (rst),
      .en  (advance),
      .d   (out_d),
      .q   (regs_out)
   );

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage RV32I pipeline, between decode and memory stages.
- Consumes the decode stage's stage_regs and computes the ALU result, branch decision/target and load/store effective address.
- Contains an iterative multi-cycle multiplier for the M-extension MUL* ops; stalls upstream while it is busy.
- Registered output feeds the memory stage.

Parameters:
- MUL_CYCLES, 32, multiplier iterations (one bit per cycle); must be 32 for RV32.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- regs_in  input  $bits(stage_regs)  decode-stage bundle: pc, ctrl, rs1_v, rs2_v, imm, rd, valid
- stall_in  input  1  downstream cannot accept; hold regs_out
- flush  input  1  kill instruction in EX and any multiply in progress
- regs_out  output  $bits(stage_regs)  registered bundle to memory stage: pc, ctrl, alu, rd, br, valid
- stall_out  output  1  upstream must hold regs_in
- br_taken  output  1  redirect fetch (combinational)
- br_target  output  32  redirect address (combinational)

Behaviour:
- Reset (synchronous, active-high):
  - regs_out all-zero, valid=0.
  - Multiplier FSM = IDLE; iteration counter = 0.
  - stall_out=0, br_taken=0.
- Define advance = !stall_in.
- Output register:
  - Loads only when advance; holds otherwise.
  - Loads the computed bundle with valid=regs_in.valid when the op is complete.
  - Loads a bubble (valid=0) when the multiplier is not in DONE.
- stall_out = stall_in | (valid MUL-class op in EX & FSM != DONE).
- ALU (single cycle):
  - Ops: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND; shift amount = operand_b[4:0].
  - Operand_b = rs2_v or imm per ctrl.
  - Loads/stores: alu = rs1_v + imm.
  - LUI: alu = imm. AUIPC: alu = pc + imm.
- Branch:
  - BEQ/BNE/BLT/BGE/BLTU/BGEU compare rs1_v vs rs2_v; br = zero-extended compare bit.
  - br_taken = regs_in.valid & !flush & (taken branch | JAL | JALR).
  - br_target = pc + imm; for JALR, (rs1_v + imm) & ~1.
  - JAL/JALR: alu = pc + 4.
- Multiplier FSM, states IDLE, BUSY, DONE:
  - IDLE -> BUSY: valid MUL/MULH/MULHSU/MULHU in EX and !flush. Latch operand magnitudes, result sign and op; counter=0.
  - BUSY: shift-add one multiplier bit per cycle; counter increments. BUSY -> DONE after MUL_CYCLES iterations.
  - DONE -> IDLE: on advance, when the result is written to regs_out. DONE holds while stall_in.
  - Any state -> IDLE on flush or rst.
- Multiply arithmetic:
  - Sign handling: MULH signed x signed; MULHSU signed rs1 x unsigned rs2; MULHU and MUL unsigned magnitudes.
  - 64-bit product is negated when the result sign is set.
  - MUL returns bits [31:0]; MULH* return bits [63:32].
- Multiply latency: op presented cycle T; BUSY T+1..T+32; DONE T+33; regs_out valid after the T+33 edge. stall_out is high T..T+32.
- Flush:
  - With advance, the next regs_out.valid=0.
  - FSM -> IDLE next cycle; stall_out drops once stall_in is low.
  - flush takes priority over a simultaneous FSM start.
- rst during BUSY behaves as flush, plus the full reset values above.
- Invalid (valid=0) inputs never start the multiplier and never assert br_taken.

Optional Feature:
- EX_MUL_EARLY_OUT_EN defined:
  - BUSY -> DONE as soon as the remaining unshifted multiplier bits are all zero.
  - Minimum 1 BUSY cycle; multiplier 0 gives result at T+2.
  - Results identical to the fixed-latency path.
- Undefined: fixed MUL_CYCLES iterations.

Decomposition:
- rv32i_types package holds:
  - stage_regs struct with the fields above
  - alu_ops enum
  - branch_funct3 enum
  - mul_funct3 enum (MUL, MULH, MULHSU, MULHU)
  - opcode enum
  - constant for the JALR LSB mask
- One sub-module: mul_iter. It contains the FSM, counter, operand/accumulator registers and sign fix-up, with a start/done/abort interface.
- Output register uses the shared register module, width $bits(stage_regs).

Test Plan:
- ADD rs1=5, rs2=7 -> next cycle regs_out.alu=12, valid=1; stall_out never high.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> alu=0xFFFFFFFE at T+34 sample; stall_out high exactly 33 cycles. MUL same operands -> 0x00000001.
- MUL/MULH rs1=0xFFFFFFFD (-3), rs2=5 -> MUL 0xFFFFFFF1, MULH 0xFFFFFFFF; MULHSU rs1=-1, rs2=2 -> 0xFFFFFFFF.
- BEQ pc=0x100, imm=0x20, rs1=rs2=9 -> br_taken=1, br_target=0x120; BNE same -> br_taken=0, br=0. JALR rs1=0x203, imm=0 -> target 0x202, alu=0x104.
- MUL reaches DONE with stall_in high 3 cycles -> regs_out held, FSM stays DONE; exactly one valid result written after stall_in drops, no duplicate.
- flush at BUSY cycle 10 -> FSM IDLE next cycle, regs_out.valid=0, stall_out low; repeat with rst -> all reset values.
